e_mdu_hilo: RTL and testbench
=============================

Name: e_mdu_hilo

Overview:
- E-stage multiply/divide unit that owns the HI/LO registers.
- Produces E_HL_data, the value the E-stage GRF write-data mux selects for mfhi/mflo.
- Executes mult/multu/div/divu with fixed multi-cycle latency, plus single-cycle mthi/mtlo writes.
- Exports a busy flag that the hazard unit uses to stall any HI/LO-related instruction in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
E_start  input  1  qualifies E_md_op for one cycle; sampled on rising clk
E_md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
E_rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source)
E_rt_data  input  32  forwarded rt operand (divisor / multiplier)
E_HL_sel  input  1  read select: 0 LO, 1 HI
E_HL_data  output  32  combinational read: E_HL_sel ? HI : LO
E_md_busy  output  1  E_start&(op 1-4) | busy_q; combinational

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy_q=0, cnt=0, pending result regs=0.
  - E_HL_data=0; E_md_busy=0 once E_start is low.
- Accept rule: an E_start at a rising edge is accepted only if busy_q=0; if busy_q=1 it is ignored entirely (the controller must stall; the bench checks the ignore).
- mult/multu:
  - Accepted at edge T0: compute the 64-bit product (signed for mult, zero-extended for multu) into pending regs.
  - Load cnt=MULT_CYCLES and set busy_q=1.
- div/divu:
  - Accepted at edge T0: pending LO=quotient, HI=remainder, then cnt=DIV_CYCLES and busy_q=1.
  - Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: the op is accepted and busy runs the full DIV_CYCLES, but HI/LO are NOT updated at commit.
- Countdown: each edge with busy_q=1 decrements cnt. At the edge where cnt goes 1->0:
  - HI/LO <= pending, except on divide-by-zero.
  - busy_q <= 0.
  - busy_q is high for exactly N cycles after T0; the new HI/LO are visible from edge T0+N.
- mthi/mtlo:
  - Accepted at edge T0: HI or LO <= E_rs_data at T0; the other register is unchanged.
  - busy_q stays 0. E_md_busy is not asserted for ops 5/6.
- Read path: E_HL_data always reflects the current HI/LO registers. During busy it shows the old values; no bypass of pending results.
- Op 0 or 7 with E_start=1: no state change.
- Back-to-back: a new E_start is accepted in the same cycle busy_q first reads 0, i.e. at edge T0+N+1 at earliest.
  - Starting at edge T0+N is ignored because busy_q is still 1 at that edge.
- Reset mid-operation aborts the op: HI/LO clear to 0 and no commit occurs.
- Implementation: the arithmetic uses native 64-bit `*` and 32-bit `/`,`%` on sign-correct operands; the latency is purely the counter.

Test Plan:
- Reset release, then mult with rs=0xFFFFFFFE(-2), rt=3 at T0 -> E_md_busy=1 for cycles T0..T0+5; at edge T0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy low after.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; during busy E_HL_data (sel=0) still shows the old LO.
- div rs=0xFFFFFFF9(-7), rt=2 -> after 10 cycles LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). divu with rs=7, rt=0 -> busy for 10 cycles, HI/LO unchanged.
- mthi rs=0x12345678, then mtlo rs=0xCAFEBABE on consecutive cycles -> E_md_busy never high; HI=0x12345678 (sel=1), LO=0xCAFEBABE (sel=0).
- Start mult, assert E_start with mtlo rs=0xAAAA at T0+2 -> ignored; LO after commit equals the product low word, not 0xAAAA. A start at T0+6 is accepted.
- Start div, drive reset=0 asynchronously mid-cycle at T0+4 -> HI=LO=0 and busy=0 immediately; no commit at T0+10 after reset release.

Source files
------------

// File: rtl/e_mdu_hilo.sv
// E-stage multiply/divide unit owning the HI/LO registers.
// Results are computed in full on the accepting edge and parked in pending
// registers; a down-counter then models the fixed unit latency before the
// pending value is committed into HI/LO.
module e_mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_start,
   input  logic [2:0]  E_md_op,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        E_HL_sel,
   output logic [31:0] E_HL_data,
   output logic        E_md_busy
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   // architectural registers
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   // in-flight operation state
   logic        busy_reg;
   logic [3:0]  cnt_reg;
   logic [31:0] pend_hi_reg;
   logic [31:0] pend_lo_reg;
   logic        pend_dz_reg;

   logic        is_md_op;
   logic        commit;

   // arithmetic datapath
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic               div_ovf;
   logic               div_zero;
   logic signed [31:0] dvd_s;
   logic signed [31:0] dvs_s;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic [31:0]        dvs_u;
   logic [31:0]        quo_u;
   logic [31:0]        rem_u;

   assign is_md_op = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU) ||
                     (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);

   assign E_md_busy = (E_start & is_md_op) | busy_reg;
   assign E_HL_data = E_HL_sel ? hi_reg : lo_reg;

   // last countdown edge of the active op
   assign commit = busy_reg && (cnt_reg == 4'd1);

   assign prod_s = $signed({{32{E_rs_data[31]}}, E_rs_data}) *
                   $signed({{32{E_rt_data[31]}}, E_rt_data});
   assign prod_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};

   // A zero divisor never commits, and the single signed overflow case
   // (-2^31 / -1) yields exactly dividend/1, so both divide by 1 instead;
   // this keeps the dividers free of undefined results.
   assign div_zero = (E_rt_data == 32'd0);
   assign div_ovf  = (E_rs_data == 32'h8000_0000) && (E_rt_data == 32'hFFFF_FFFF);
   assign dvd_s    = $signed(E_rs_data);
   assign dvs_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(E_rt_data);
   assign quo_s    = dvd_s / dvs_s;
   assign rem_s    = dvd_s % dvs_s;
   assign dvs_u    = div_zero ? 32'd1 : E_rt_data;
   assign quo_u    = E_rs_data / dvs_u;
   assign rem_u    = E_rs_data % dvs_u;

   // accept new mult/div ops when idle, otherwise count down the latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_reg    <= 1'b0;
         cnt_reg     <= 4'd0;
         pend_hi_reg <= 32'd0;
         pend_lo_reg <= 32'd0;
         pend_dz_reg <= 1'b0;
      end else if (busy_reg) begin
         cnt_reg <= cnt_reg - 4'd1;
         if (cnt_reg == 4'd1) begin
            busy_reg <= 1'b0;
         end
      end else if (E_start) begin
         case (E_md_op)
            OP_MULT: begin
               {pend_hi_reg, pend_lo_reg} <= prod_s;
               pend_dz_reg <= 1'b0;
               cnt_reg     <= MULT_LOAD;
               busy_reg    <= 1'b1;
            end
            OP_MULTU: begin
               {pend_hi_reg, pend_lo_reg} <= prod_u;
               pend_dz_reg <= 1'b0;
               cnt_reg     <= MULT_LOAD;
               busy_reg    <= 1'b1;
            end
            OP_DIV: begin
               pend_hi_reg <= rem_s;
               pend_lo_reg <= quo_s;
               pend_dz_reg <= div_zero;
               cnt_reg     <= DIV_LOAD;
               busy_reg    <= 1'b1;
            end
            OP_DIVU: begin
               pend_hi_reg <= rem_u;
               pend_lo_reg <= quo_u;
               pend_dz_reg <= div_zero;
               cnt_reg     <= DIV_LOAD;
               busy_reg    <= 1'b1;
            end
            default: begin
               // mthi/mtlo, none and reserved leave the engine idle
            end
         endcase
      end
   end

   // HI/LO update: commit pending results or take direct mthi/mtlo writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_reg <= 32'd0;
         lo_reg <= 32'd0;
      end else if (commit) begin
         if (!pend_dz_reg) begin
            hi_reg <= pend_hi_reg;
            lo_reg <= pend_lo_reg;
         end
      end else if (!busy_reg && E_start) begin
         if (E_md_op == OP_MTHI) begin
            hi_reg <= E_rs_data;
         end else if (E_md_op == OP_MTLO) begin
            lo_reg <= E_rs_data;
         end
      end
   end

endmodule

// File: tb/tb_e_mdu_hilo.sv
// Self-checking bench for e_mdu_hilo: directed scenarios followed by random
// op streams, all compared against a cycle-indexed behavioural model.
module tb_e_mdu_hilo;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic        E_start;
   logic [2:0]  E_md_op;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic        E_HL_sel;
   logic [31:0] E_HL_data;
   logic        E_md_busy;

   int checks;
   int failures;

   // model state: committed HI/LO, and an outstanding result that lands on
   // a known edge number
   int          edge_n;
   bit          m_act;
   int          m_done;
   bit          m_dz;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;

   e_mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .E_start   (E_start),
      .E_md_op   (E_md_op),
      .E_rs_data (E_rs_data),
      .E_rt_data (E_rt_data),
      .E_HL_sel  (E_HL_sel),
      .E_HL_data (E_HL_data),
      .E_md_busy (E_md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint unsigned x, y;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = {32'd0, a};
         y = {32'd0, b};
      end
      return x * y;
   endfunction

   // returns {remainder, quotient}
   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'd0, a});
         y = longint'({32'd0, b});
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic model_reset();
      m_act = 0;
      m_dz  = 0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
   endtask

   task automatic model_edge(input bit st, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      bit was_busy;
      logic [63:0] res;
      was_busy = m_act;
      edge_n++;
      if (m_act && edge_n == m_done) begin
         if (!m_dz) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
         m_act = 0;
      end
      if (!was_busy && st) begin
         case (op)
            3'd1, 3'd2: begin
               res = ref_mul(op == 3'd1, rs, rt);
               {m_phi, m_plo} = res;
               m_dz = 0;
               m_act = 1;
               m_done = edge_n + MULT_N;
            end
            3'd3, 3'd4: begin
               m_dz = (rt == 32'd0);
               if (!m_dz) begin
                  res = ref_div(op == 3'd3, rs, rt);
                  {m_phi, m_plo} = res;
               end
               m_act = 1;
               m_done = edge_n + DIV_N;
            end
            3'd5: m_hi = rs;
            3'd6: m_lo = rs;
            default: ;
         endcase
      end
   endtask

   // one clock cycle: entered just after a falling edge, returns at the next
   task automatic cycle(input bit st, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      bit exp_busy;
      E_start   = st;
      E_md_op   = op;
      E_rs_data = rs;
      E_rt_data = rt;
      #1;
      exp_busy = (st && op >= 3'd1 && op <= 3'd4) || m_act;
      check32("busy", {31'd0, E_md_busy}, {31'd0, exp_busy});
      @(posedge clk);
      model_edge(st, op, rs, rt);
      #1;
      E_HL_sel = 1'b0;
      #1;
      check32("lo", E_HL_data, m_lo);
      E_HL_sel = 1'b1;
      #1;
      check32("hi", E_HL_data, m_hi);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   // direct comparison of HI/LO against hand-derived constants
   task automatic expect_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      E_HL_sel = 1'b1;
      #1;
      check32({tag, "_hi"}, E_HL_data, hi);
      E_HL_sel = 1'b0;
      #1;
      check32({tag, "_lo"}, E_HL_data, lo);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      edge_n   = 0;
      model_reset();
      reset     = 1'b0;
      E_start   = 1'b0;
      E_md_op   = 3'd0;
      E_rs_data = 32'd0;
      E_rt_data = 32'd0;
      E_HL_sel  = 1'b0;

      repeat (2) @(negedge clk);
      expect_hl("rst", 32'd0, 32'd0);
      check32("rst_busy", {31'd0, E_md_busy}, 32'd0);
      reset = 1'b1;

      // mult -2 * 3
      cycle(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
      idle(MULT_N);
      expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // multu max*max, old LO visible during busy
      cycle(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(MULT_N);
      expect_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);

      // signed divide -7 / 2
      cycle(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
      idle(DIV_N);
      expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // divide by zero: full busy, no update
      cycle(1'b1, 3'd4, 32'd7, 32'd0);
      idle(DIV_N);
      expect_hl("divz", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // signed overflow case
      cycle(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DIV_N);
      expect_hl("ovf", 32'd0, 32'h8000_0000);

      // mthi / mtlo back to back
      cycle(1'b1, 3'd5, 32'h1234_5678, 32'd0);
      cycle(1'b1, 3'd6, 32'hCAFE_BABE, 32'd0);
      expect_hl("mtx", 32'h1234_5678, 32'hCAFE_BABE);

      // mtlo while busy ignored; start at T0+N ignored; start at T0+N+1 taken
      cycle(1'b1, 3'd1, 32'd6, 32'd7);          // T0
      idle(1);                                   // T0+1
      cycle(1'b1, 3'd6, 32'h0000_AAAA, 32'd0);  // T0+2 ignored
      idle(2);                                   // T0+3, T0+4
      cycle(1'b1, 3'd5, 32'hDEAD_0001, 32'd0);  // T0+5 ignored
      expect_hl("ign", 32'd0, 32'd42);
      cycle(1'b1, 3'd5, 32'hBEEF_0002, 32'd0);  // T0+6 accepted
      expect_hl("b2b", 32'hBEEF_0002, 32'd42);

      // asynchronous reset in the middle of a divide
      cycle(1'b1, 3'd3, 32'd100, 32'd7);
      idle(3);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check32("arst_busy", {31'd0, E_md_busy}, 32'd0);
      expect_hl("arst", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      idle(DIV_N);
      expect_hl("nocommit", 32'd0, 32'd0);

      // random op stream
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      end
      idle(DIV_N + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
